// File: rtl/wiredpanda_io_pkg.sv
// Shared constants and helpers for the wiredpanda push-button I/O blocks.
package wiredpanda_io_pkg;

    localparam int unsigned SYNC_STAGES             = 2;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;

    // Width needed to hold values 0..n without wrapping.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Flop-chain synchronizer for a single asynchronous input.
module sync_2ff
    import wiredpanda_io_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a bouncy push-button: stable level plus one-cycle rise/fall pulses.
module button_debouncer
    import wiredpanda_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
)
(
    input  logic input_clock1_clk_1,
    input  logic input_push_button2_rst_n_2,
    input  logic input_push_button1_d_1,
    output logic output_led1_level_3,
    output logic output_led2_rise_4,
    output logic output_led3_fall_5,
    output logic output_led4_busy_6
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("button_debouncer: DEBOUNCE_CYCLES must be at least 2");
    end

    logic             w_sync;
    logic [CNT_W-1:0] r_count;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;

    logic [CNT_W-1:0] w_count_nxt;
    logic             w_level_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;

    sync_2ff u_sync (
        .i_clk   (input_clock1_clk_1),
        .i_rst_n (input_push_button2_rst_n_2),
        .i_d     (input_push_button1_d_1),
        .o_q     (w_sync)
    );

    // Stability count: any agreement clears it, the last disagreeing cycle commits the level.
    always_comb begin
        w_count_nxt = '0;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        if (w_sync != r_level) begin
            if (r_count == CNT_LAST) begin
                w_level_nxt = w_sync;
                w_rise_nxt  = w_sync;
                w_fall_nxt  = ~w_sync;
            end else begin
                w_count_nxt = r_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge input_clock1_clk_1 or negedge input_push_button2_rst_n_2) begin
        if (!input_push_button2_rst_n_2) begin
            r_count <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_busy  <= (w_count_nxt != '0);
        end
    end

    assign output_led1_level_3 = r_level;
    assign output_led2_rise_4  = r_rise;
    assign output_led3_fall_5  = r_fall;
    assign output_led4_busy_6  = r_busy;

endmodule
